// File: rtl/key_cfg_ctrl.sv
// Key-driven bit-loading selector: steps through NUM_CFG settings on key pulses,
// offers each new setting to the DMT datapath over a req/ack handshake, then locks out briefly.
module key_cfg_ctrl #(
    parameter int unsigned NUM_CFG = 4,
    parameter int unsigned CFG_W   = 3,
    parameter int unsigned HOLDOFF = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_pulse,
    input  logic               cfg_ack,
    output logic               cfg_req,
    output logic [CFG_W-1:0]   cfg_data,
    output logic [CFG_W-1:0]   cfg_active,
    output logic [NUM_CFG-1:0] led,
    output logic               busy,
    output logic [7:0]         drop_cnt
);

    localparam int unsigned      CntW     = 21;
    localparam logic [CntW-1:0]  HoldLast = CntW'(HOLDOFF - 1);
    localparam logic [CFG_W-1:0] SelLast  = CFG_W'(NUM_CFG - 1);

    if ((1 << CFG_W) <= NUM_CFG) begin : gen_param_check
        $error("key_cfg_ctrl: 2**CFG_W must exceed NUM_CFG");
    end

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [CFG_W-1:0]   sel_q, sel_d;
    logic               pending_q, pending_d;
    logic [CntW-1:0]    hold_cnt_q, hold_cnt_d;
    logic               cfg_req_q, cfg_req_d;
    logic [CFG_W-1:0]   cfg_data_q, cfg_data_d;
    logic [CFG_W-1:0]   cfg_active_q, cfg_active_d;
    logic [NUM_CFG-1:0] led_q, led_d;
    logic               busy_q, busy_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic [CFG_W-1:0]   sel_next;
    logic [NUM_CFG-1:0] led_from_data;
    logic               advance;

    always_comb begin
        sel_next = (sel_q == SelLast) ? '0 : sel_q + CFG_W'(1);
    end

    // Setting value is index+1, so LED bit i lights for value i+1.
    always_comb begin
        for (int i = 0; i < NUM_CFG; i++) begin
            led_from_data[i] = (cfg_data_q == CFG_W'(i + 1));
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        pending_d    = pending_q;
        hold_cnt_d   = hold_cnt_q;
        cfg_req_d    = cfg_req_q;
        cfg_data_d   = cfg_data_q;
        cfg_active_d = cfg_active_q;
        led_d        = led_q;
        drop_cnt_d   = drop_cnt_q;
        advance      = 1'b0;

        // While busy, remember one extra press; any beyond that is counted and discarded.
        if (key_pulse && (state_q != StIdle)) begin
            if (pending_q) begin
                if (drop_cnt_q != 8'hff) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end else begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (key_pulse) begin
                    advance = 1'b1;
                end
            end
            StReq: begin
                if (cfg_ack) begin
                    cfg_req_d    = 1'b0;
                    cfg_active_d = cfg_data_q;
                    led_d        = led_from_data;
                    hold_cnt_d   = '0;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (hold_cnt_q == HoldLast) begin
                    hold_cnt_d = '0;
                    // A press landing on the final lockout cycle is served right away.
                    if (pending_q || key_pulse) begin
                        advance   = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (advance) begin
            sel_d      = sel_next;
            cfg_data_d = sel_next + CFG_W'(1);
            cfg_req_d  = 1'b1;
            state_d    = StReq;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            pending_q    <= 1'b0;
            hold_cnt_q   <= '0;
            cfg_req_q    <= 1'b0;
            cfg_data_q   <= CFG_W'(1);
            cfg_active_q <= CFG_W'(1);
            led_q        <= NUM_CFG'(1);
            busy_q       <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            pending_q    <= pending_d;
            hold_cnt_q   <= hold_cnt_d;
            cfg_req_q    <= cfg_req_d;
            cfg_data_q   <= cfg_data_d;
            cfg_active_q <= cfg_active_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign cfg_req    = cfg_req_q;
    assign cfg_data   = cfg_data_q;
    assign cfg_active = cfg_active_q;
    assign led        = led_q;
    assign busy       = busy_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Scoreboard bench for key_cfg_ctrl: stimulus queues expected offer/accept/idle events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_key_cfg_ctrl;

    localparam int NumCfg  = 4;
    localparam int CfgW    = 3;
    localparam int Holdoff = 4;

    localparam int KOffer = 0;
    localparam int KDone  = 1;
    localparam int KIdle  = 2;

    typedef struct {
        int kind;
        int data;
        int active;
        int led_v;
        int drop;
        int cycles;
    } exp_t;

    logic              clk       = 1'b0;
    logic              rst       = 1'b0;
    logic              key_pulse = 1'b0;
    logic              cfg_ack   = 1'b0;
    logic              cfg_req;
    logic [CfgW-1:0]   cfg_data;
    logic [CfgW-1:0]   cfg_active;
    logic [NumCfg-1:0] led;
    logic              busy;
    logic [7:0]        drop_cnt;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q[$];

    int b_val[4] = '{2, 3, 4, 1};
    int b_led[4] = '{2, 4, 8, 1};

    always #5 clk = ~clk;

    key_cfg_ctrl #(
        .NUM_CFG(NumCfg),
        .CFG_W  (CfgW),
        .HOLDOFF(Holdoff)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .cfg_ack   (cfg_ack),
        .cfg_req   (cfg_req),
        .cfg_data  (cfg_data),
        .cfg_active(cfg_active),
        .led       (led),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    function automatic void chk(input string name, input logic [31:0] act, input int req);
        n_vec++;
        if (act !== 32'(req)) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endfunction

    function automatic void expect_ev(input int kind, input int data, input int active,
                                      input int led_v, input int drop, input int cycles);
        exp_t e;
        e.kind   = kind;
        e.data   = data;
        e.active = active;
        e.led_v  = led_v;
        e.drop   = drop;
        e.cycles = cycles;
        exp_q.push_back(e);
    endfunction

    function automatic bit pop_ev(input int kind, input string name, output exp_t e);
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: got unexpected event, want none queued", name);
            return 1'b0;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            n_miss++;
            $display("FAIL %s: got event kind %0d, want kind %0d", name, kind, e.kind);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor
    logic            prev_req  = 1'b0;
    logic            prev_busy = 1'b0;
    int              hold_cnt  = 0;
    int              req_cnt   = 0;
    logic [CfgW-1:0] held_data = '0;
    exp_t            me;

    always @(negedge clk) begin
        if (cfg_req === 1'b1 && prev_req === 1'b0) begin
            if (pop_ev(KOffer, "offer", me)) begin
                chk("offer_data", 32'(cfg_data), me.data);
                chk("offer_drop", 32'(drop_cnt), me.drop);
                if (me.cycles >= 0) chk("offer_hold_len", 32'(hold_cnt), me.cycles);
            end
            req_cnt   = 1;
            held_data = cfg_data;
        end else if (cfg_req === 1'b1 && prev_req === 1'b1) begin
            chk("data_stable", 32'(cfg_data), int'(held_data));
            req_cnt++;
        end

        if (cfg_req === 1'b0 && prev_req === 1'b1) begin
            if (pop_ev(KDone, "accept", me)) begin
                chk("accept_active", 32'(cfg_active), me.active);
                chk("accept_led", 32'(led), me.led_v);
                chk("accept_drop", 32'(drop_cnt), me.drop);
                if (me.cycles >= 0) chk("req_len", 32'(req_cnt), me.cycles);
            end
            hold_cnt = (busy === 1'b1) ? 1 : 0;
        end else if (busy === 1'b1 && cfg_req === 1'b0) begin
            hold_cnt++;
        end

        if (busy === 1'b0 && prev_busy === 1'b1) begin
            if (pop_ev(KIdle, "idle", me)) chk("hold_len", 32'(hold_cnt), me.cycles);
        end

        prev_req  = cfg_req;
        prev_busy = busy;
    end

    // Stimulus helpers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        key_pulse = 1'b1;
        step(1);
        key_pulse = 1'b0;
    endtask

    task automatic wait_req();
        int t = 0;
        while (cfg_req !== 1'b1 && t < 50) begin
            step(1);
            t++;
        end
        if (cfg_req !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_req: got no cfg_req, want one within 50 cycles");
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 100) begin
            step(1);
            t++;
        end
        if (busy !== 1'b0) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_idle: got busy still high, want low within 100 cycles");
        end
    endtask

    task automatic ack_after(input int lag);
        wait_req();
        step(lag - 1);
        cfg_ack = 1'b1;
        step(1);
        cfg_ack = 1'b0;
    endtask

    initial begin
        int t;

        // Reset state
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_req", 32'(cfg_req), 0);
        chk("rst_data", 32'(cfg_data), 1);
        chk("rst_active", 32'(cfg_active), 1);
        chk("rst_led", 32'(led), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // Single press, ack three cycles into the request
        expect_ev(KOffer, 2, 0, 0, 0, -1);
        expect_ev(KDone, 0, 2, 2, 0, 3);
        expect_ev(KIdle, 0, 0, 0, 0, Holdoff);
        pulse();
        ack_after(3);
        wait_idle();
        chk("a_active", 32'(cfg_active), 2);

        // Four accepted presses from reset wrap back to setting 1
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_ev(KOffer, b_val[i], 0, 0, 0, -1);
            expect_ev(KDone, 0, b_val[i], b_led[i], 0, 1);
            expect_ev(KIdle, 0, 0, 0, 0, Holdoff);
            pulse();
            ack_after(1);
            wait_idle();
        end
        chk("b_led_wrap", 32'(led), 1);

        // Three presses during a stalled request: one pending, two dropped
        expect_ev(KOffer, 2, 0, 0, 0, -1);
        expect_ev(KDone, 0, 2, 2, 2, -1);
        expect_ev(KOffer, 3, 0, 0, 2, Holdoff);
        expect_ev(KDone, 0, 3, 4, 2, 1);
        expect_ev(KIdle, 0, 0, 0, 0, Holdoff);
        pulse();
        wait_req();
        repeat (3) begin
            pulse();
            step(1);
        end
        chk("c_drop", 32'(drop_cnt), 2);
        ack_after(1);
        ack_after(1);
        wait_idle();

        // Press coinciding with ack: accepted, press becomes pending, follow-up wraps to 1
        expect_ev(KOffer, 4, 0, 0, 2, -1);
        expect_ev(KDone, 0, 4, 8, 2, 2);
        expect_ev(KOffer, 1, 0, 0, 2, Holdoff);
        expect_ev(KDone, 0, 1, 1, 2, 1);
        expect_ev(KIdle, 0, 0, 0, 0, Holdoff);
        pulse();
        wait_req();
        step(1);
        key_pulse = 1'b1;
        cfg_ack   = 1'b1;
        step(1);
        key_pulse = 1'b0;
        cfg_ack   = 1'b0;
        ack_after(1);
        wait_idle();
        chk("d_drop", 32'(drop_cnt), 2);

        // Reset during an offer of 3 (with key and ack in the same cycle)
        expect_ev(KOffer, 2, 0, 0, 2, -1);
        expect_ev(KDone, 0, 2, 2, 2, 1);
        expect_ev(KIdle, 0, 0, 0, 0, Holdoff);
        expect_ev(KOffer, 3, 0, 0, 2, -1);
        expect_ev(KDone, 0, 1, 1, 0, -1);
        expect_ev(KIdle, 0, 0, 0, 0, 0);
        pulse();
        ack_after(1);
        wait_idle();
        pulse();
        wait_req();
        step(1);
        rst       = 1'b1;
        key_pulse = 1'b1;
        cfg_ack   = 1'b1;
        step(1);
        rst       = 1'b0;
        key_pulse = 1'b0;
        cfg_ack   = 1'b0;
        chk("e_req", 32'(cfg_req), 0);
        chk("e_active", 32'(cfg_active), 1);
        chk("e_data", 32'(cfg_data), 1);
        chk("e_drop", 32'(drop_cnt), 0);
        step(2);
        cfg_ack = 1'b1;
        step(1);
        cfg_ack = 1'b0;
        step(2);
        chk("e_late_ack_req", 32'(cfg_req), 0);
        chk("e_late_ack_active", 32'(cfg_active), 1);
        chk("e_late_ack_busy", 32'(busy), 0);

        // 300 surplus presses during a stalled request saturate the drop counter
        expect_ev(KOffer, 2, 0, 0, 0, -1);
        expect_ev(KDone, 0, 2, 2, 255, -1);
        expect_ev(KOffer, 3, 0, 0, 255, Holdoff);
        expect_ev(KDone, 0, 3, 4, 255, 1);
        expect_ev(KIdle, 0, 0, 0, 0, Holdoff);
        pulse();
        wait_req();
        key_pulse = 1'b1;
        step(300);
        key_pulse = 1'b0;
        chk("f_drop_sat", 32'(drop_cnt), 255);
        ack_after(1);
        ack_after(1);
        wait_idle();

        // Drain the scoreboard
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step(1);
            t++;
        end
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_miss++;
            $display("FAIL missing_event: got nothing, want event kind %0d data %0d active %0d",
                     e.kind, e.data, e.active);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
